// File: rtl/register_scoreboard.sv
// register_scoreboard
//   Producer-side bookkeeping for the pipelined RV32 core. It counts the
//   register writes that have issued but not yet retired, and it flags each
//   outstanding load. From that state it raises the decode stall.
//
//   Issue handshake: an instruction is accepted on a rising edge when all of
//   issueValid, !issueFlush and !issueStall hold in the preceding cycle.
//   issueStall is combinational and depends only on the current inputs and the
//   state, so it is valid within the same cycle as issueValid. Load responses
//   and retires have no back-pressure. They are consumed in the cycle they
//   are presented.
//
// Ports
//   clk, reset              : clock; synchronous active-high reset
//   issueValid/issueFlush   : decode presents / kills an instruction
//   issueReadIndex1/2       : source registers (0 = no read)
//   issueWriteEnable/Index  : destination register of the issuing instruction
//   issueIsLoad             : issuing instruction is a load
//   loadResponseValid/Index : load data returns for a destination
//   retireValid/WriteIndex  : writeback commits a register write
//   issueStall              : decode must hold this cycle
//   pendingMask             : bit i = in-flight counter of register i is non-zero
//   loadPendingMask         : bit i = outstanding load to register i
//   totalInFlight           : sum of all in-flight counters
//   underflowError          : sticky, set when a retire targets a register with counter 0
module register_scoreboard #(
  parameter int COUNT_WIDTH = 2,
  parameter int NUM_REGS    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issueValid,
  input  logic                   issueFlush,
  input  logic [4:0]             issueReadIndex1,
  input  logic [4:0]             issueReadIndex2,
  input  logic                   issueWriteEnable,
  input  logic [4:0]             issueWriteIndex,
  input  logic                   issueIsLoad,
  input  logic                   loadResponseValid,
  input  logic [4:0]             loadResponseIndex,
  input  logic                   retireValid,
  input  logic [4:0]             retireWriteIndex,
  output logic                   issueStall,
  output logic [NUM_REGS-1:0]    pendingMask,
  output logic [NUM_REGS-1:0]    loadPendingMask,
  output logic [COUNT_WIDTH+4:0] totalInFlight,
  output logic                   underflowError
);

  localparam int TW = COUNT_WIDTH + 5;
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  logic [COUNT_WIDTH-1:0] r_count [NUM_REGS];
  logic [NUM_REGS-1:0]    r_load_pending;
  logic [TW-1:0]          r_total;
  logic                   r_underflow;

  logic w_raw1, w_raw2, w_waw_sat, w_load_dup;
  logic w_fire, w_retire_ok, w_retire_under;
  logic [NUM_REGS-1:0] w_inc_vec, w_dec_vec, w_lp_set, w_lp_clr;

  // A load response that arrives in the same cycle as the dependent read is
  // forwardable, so it removes the hazard.
  always_comb begin
    w_raw1 = (issueReadIndex1 != 5'd0) && r_load_pending[issueReadIndex1] &&
             !(loadResponseValid && (loadResponseIndex == issueReadIndex1));
    w_raw2 = (issueReadIndex2 != 5'd0) && r_load_pending[issueReadIndex2] &&
             !(loadResponseValid && (loadResponseIndex == issueReadIndex2));
    // A same-cycle retire of the destination frees one slot, so a counter at
    // its maximum does not stall in that cycle.
    w_waw_sat = issueWriteEnable && (issueWriteIndex != 5'd0) &&
                (r_count[issueWriteIndex] == CMAX) &&
                !(retireValid && (retireWriteIndex == issueWriteIndex));
    // Each destination may have only one outstanding load.
    w_load_dup = issueIsLoad && issueWriteEnable && (issueWriteIndex != 5'd0) &&
                 r_load_pending[issueWriteIndex] &&
                 !(loadResponseValid && (loadResponseIndex == issueWriteIndex));
    issueStall = issueValid && !issueFlush &&
                 (w_raw1 || w_raw2 || w_waw_sat || w_load_dup);
    w_fire = issueValid && !issueFlush && !issueStall &&
             issueWriteEnable && (issueWriteIndex != 5'd0);
    w_retire_ok    = retireValid && (retireWriteIndex != 5'd0) &&
                     (r_count[retireWriteIndex] != '0);
    w_retire_under = retireValid && (retireWriteIndex != 5'd0) &&
                     (r_count[retireWriteIndex] == '0);
  end

  // Decode each event into a one-hot per-register vector. Bit 0 never sets
  // because every event above already excludes index 0.
  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    w_lp_set  = '0;
    w_lp_clr  = '0;
    if (w_fire) w_inc_vec[issueWriteIndex] = 1'b1;
    if (w_fire && issueIsLoad) w_lp_set[issueWriteIndex] = 1'b1;
    if (w_retire_ok) w_dec_vec[retireWriteIndex] = 1'b1;
    if (loadResponseValid && (loadResponseIndex != 5'd0))
      w_lp_clr[loadResponseIndex] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_count[i] <= '0;
      r_load_pending <= '0;
      r_total        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_count[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        // An issue and a retire on the same register cancel each other out.
        case ({w_inc_vec[i], w_dec_vec[i]})
          2'b10:   r_count[i] <= r_count[i] + 1'b1;
          2'b01:   r_count[i] <= r_count[i] - 1'b1;
          default: r_count[i] <= r_count[i];
        endcase
      end
      // A new load that issues as the old one returns leaves the flag set.
      r_load_pending <= w_lp_set | (r_load_pending & ~w_lp_clr);
      r_total        <= r_total + TW'(w_fire) - TW'(w_retire_ok);
      r_underflow    <= r_underflow | w_retire_under;
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int i = 1; i < NUM_REGS; i++) pendingMask[i] = (r_count[i] != '0);
  end

  assign loadPendingMask = {r_load_pending[NUM_REGS-1:1], 1'b0};
  assign totalInFlight   = r_total;
  assign underflowError  = r_underflow;

endmodule

// File: tb/tb_register_scoreboard.sv
// Testbench for register_scoreboard. It applies a table of directed vectors
// one cycle at a time. For each vector it checks the combinational stall
// before the edge, and it checks the registered outputs after the edge. A
// short hand-written sequence then covers the same-cycle stall changes.
module tb_register_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issueValid = 1'b0, issueFlush = 1'b0;
  logic [4:0]  issueReadIndex1 = '0, issueReadIndex2 = '0;
  logic        issueWriteEnable = 1'b0;
  logic [4:0]  issueWriteIndex = '0;
  logic        issueIsLoad = 1'b0;
  logic        loadResponseValid = 1'b0;
  logic [4:0]  loadResponseIndex = '0;
  logic        retireValid = 1'b0;
  logic [4:0]  retireWriteIndex = '0;
  logic        issueStall;
  logic [31:0] pendingMask, loadPendingMask;
  logic [6:0]  totalInFlight;
  logic        underflowError;

  register_scoreboard #(.COUNT_WIDTH(2), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .issueValid(issueValid), .issueFlush(issueFlush),
    .issueReadIndex1(issueReadIndex1), .issueReadIndex2(issueReadIndex2),
    .issueWriteEnable(issueWriteEnable), .issueWriteIndex(issueWriteIndex),
    .issueIsLoad(issueIsLoad),
    .loadResponseValid(loadResponseValid), .loadResponseIndex(loadResponseIndex),
    .retireValid(retireValid), .retireWriteIndex(retireWriteIndex),
    .issueStall(issueStall), .pendingMask(pendingMask),
    .loadPendingMask(loadPendingMask), .totalInFlight(totalInFlight),
    .underflowError(underflowError)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, v, fl;
    logic [4:0]  rs1, rs2;
    logic        we;
    logic [4:0]  wi;
    logic        ld, lrv;
    logic [4:0]  lri;
    logic        rv;
    logic [4:0]  ri;
    logic        e_stall;
    logic [31:0] e_pm, e_lpm;
    logic [6:0]  e_tot;
    logic        e_uf;
  } vec_t;

  vec_t vecs[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t mk(input int rst, v, fl, rs1, rs2, we, wi, ld,
                              lrv, lri, rv, ri, st, input logic [31:0] pm,
                              input logic [31:0] lpm, input int tot, uf);
    vec_t r;
    r.rst = rst[0]; r.v = v[0]; r.fl = fl[0];
    r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0];
    r.we = we[0]; r.wi = wi[4:0]; r.ld = ld[0];
    r.lrv = lrv[0]; r.lri = lri[4:0];
    r.rv = rv[0]; r.ri = ri[4:0];
    r.e_stall = st[0]; r.e_pm = pm; r.e_lpm = lpm;
    r.e_tot = tot[6:0]; r.e_uf = uf[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver
  task automatic drive(input vec_t t);
    reset = t.rst; issueValid = t.v; issueFlush = t.fl;
    issueReadIndex1 = t.rs1; issueReadIndex2 = t.rs2;
    issueWriteEnable = t.we; issueWriteIndex = t.wi; issueIsLoad = t.ld;
    loadResponseValid = t.lrv; loadResponseIndex = t.lri;
    retireValid = t.rv; retireWriteIndex = t.ri;
  endtask

  task automatic run_vec(input int k, input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    chk($sformatf("v%0d stall", k), 32'(issueStall), 32'(t.e_stall));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d pendingMask", k), pendingMask, t.e_pm);
    chk($sformatf("v%0d loadPendingMask", k), loadPendingMask, t.e_lpm);
    chk($sformatf("v%0d totalInFlight", k), 32'(totalInFlight), 32'(t.e_tot));
    chk($sformatf("v%0d underflowError", k), 32'(underflowError), 32'(t.e_uf));
  endtask

  initial begin
    //           rst v fl rs1 rs2 we wi ld lrv lri rv ri st  pm     lpm   tot uf
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h00, 0, 0)); // 0 reset
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 32'h20, 32'h00, 1, 0)); // 1 ALU x5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 32'h00, 32'h00, 0, 0)); // 2 retire x5
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 32'h80, 32'h80, 1, 0)); // 3 load x7
    vecs.push_back(mk(0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 32'h80, 1, 0)); // 4 rs1=x7 stalls
    vecs.push_back(mk(0, 1, 0, 7, 0, 0, 0, 0, 1, 7, 0, 0, 0, 32'h80, 32'h00, 1, 0)); // 5 +response
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 32'h00, 32'h00, 0, 0)); // 6 retire x7
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 32'h08, 32'h00, 1, 0)); // 7 x3 #1
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 32'h08, 32'h00, 2, 0)); // 8 x3 #2
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 32'h08, 32'h00, 3, 0)); // 9 x3 #3
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 32'h08, 32'h00, 3, 0)); // 10 saturated
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 1, 3, 0, 32'h08, 32'h00, 3, 0)); // 11 +retire x3
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h00, 0, 0)); // 12 reset
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h00, 32'h00, 0, 0)); // 13 all x0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 32'h00, 32'h00, 0, 1)); // 14 underflow x9
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h00, 0, 1)); // 15 sticky
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 32'h04, 32'h00, 1, 1)); // 16 ALU x2
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 32'h14, 32'h10, 2, 1)); // 17 load x4
    vecs.push_back(mk(0, 1, 1, 4, 0, 1, 6, 0, 0, 0, 0, 0, 0, 32'h14, 32'h10, 2, 1)); // 18 flush hazard
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 1, 32'h14, 32'h10, 2, 1)); // 19 load dup
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 4, 1, 1, 4, 0, 0, 0, 32'h14, 32'h10, 3, 1)); // 20 dup+resp, set wins
    vecs.push_back(mk(0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h14, 32'h10, 3, 1)); // 21 rs2 hazard
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h00, 0, 0)); // 22 reset mid-op
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 4, 0, 32'h00, 32'h00, 0, 1)); // 23 stale resp/retire
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h00, 0, 0)); // 24 reset

    foreach (vecs[k]) run_vec(k, vecs[k]);

    // Hand sequence: within one cycle, the stall follows issueValid and the
    // response index.
    @(negedge clk);
    drive(mk(0, 1, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    drive(mk(0, 1, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("seq stall raw x10", 32'(issueStall), 32'd1);
    issueValid = 1'b0;
    #1 chk("seq stall no valid", 32'(issueStall), 32'd0);
    issueValid = 1'b1; loadResponseValid = 1'b1; loadResponseIndex = 5'd11;
    #1 chk("seq stall other resp", 32'(issueStall), 32'd1);
    loadResponseIndex = 5'd10;
    #1 chk("seq stall fwd resp", 32'(issueStall), 32'd0);
    @(posedge clk);
    #1;
    chk("seq lpm cleared", loadPendingMask, 32'h0);
    chk("seq pm x10", pendingMask, 32'h400);
    chk("seq tot", 32'(totalInFlight), 32'd1);
    chk("seq uf", 32'(underflowError), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
